mul4_fitness_evaluator: RTL

Sequential test harness on the far side of the evolved 2-bit × 2-bit bit-sliced multiplier candidates. It drives the four 16-lane stimulus vectors a1/a0/b1/b0, which cover all 16 input combinations exhaustively. It then captures the candidate's y3..y0, scores bit-exact agreement with the golden product, and reports a fitness value per candidate over a valid/ready handshake. It also tracks the best candidate seen since reset for the tournament loop.

---
 rtl/mul4_eval_pkg.sv | 38 +++
 rtl/mul4_fitness_evaluator_popcount16.sv | 15 +
 rtl/mul4_fitness_evaluator.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mul4_eval_pkg.sv
// Shared types and constants for the 2x2-bit multiplier fitness evaluator:
// FSM states, exhaustive 16-lane stimulus vectors and the golden product words.
package mul4_eval_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SCORE   = 3'd3,
      ST_RESULT  = 3'd4
   } state_t;

   // Lane i carries a = i[3:2], b = i[1:0].
   localparam logic [15:0] STIM_A1 = 16'hFF00;
   localparam logic [15:0] STIM_A0 = 16'hF0F0;
   localparam logic [15:0] STIM_B1 = 16'hCCCC;
   localparam logic [15:0] STIM_B0 = 16'hAAAA;

   localparam logic [15:0] GOLD_Y0 = 16'hA0A0;
   localparam logic [15:0] GOLD_Y1 = 16'h6AC0;
   localparam logic [15:0] GOLD_Y2 = 16'h4C00;
   localparam logic [15:0] GOLD_Y3 = 16'h8000;

   localparam logic [6:0] MAX_SCORE = 7'd64;

   function automatic logic [15:0] gold_word(input logic [1:0] k);
      logic [15:0] w;
      case (k)
         2'd0:    w = GOLD_Y0;
         2'd1:    w = GOLD_Y1;
         2'd2:    w = GOLD_Y2;
         2'd3:    w = GOLD_Y3;
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mul4_fitness_evaluator_popcount16.sv
// Combinational population count of a 16-bit word.
module popcount16 (
   input  logic [15:0] din,
   output logic [4:0]  count
);

   // Sum of set bits
   always_comb begin
      count = 5'd0;
      for (int i = 0; i < 16; i++) begin
         count = count + {4'd0, din[i]};
      end
   end

endmodule

// File: rtl/mul4_fitness_evaluator.sv
// Drives exhaustive stimulus into a 2x2 multiplier candidate, scores its outputs
// bit-for-bit against the golden product and tracks the best candidate since reset.
module mul4_fitness_evaluator
   import mul4_eval_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int ID_W          = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_valid,
   output logic            start_ready,
   output logic [15:0]     a1,
   output logic [15:0]     a0,
   output logic [15:0]     b1,
   output logic [15:0]     b0,
   input  logic [15:0]     y3,
   input  logic [15:0]     y2,
   input  logic [15:0]     y1,
   input  logic [15:0]     y0,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [6:0]      res_score,
   output logic            res_perfect,
   output logic [ID_W-1:0] res_id,
   output logic [6:0]      best_score,
   output logic [ID_W-1:0] best_id
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t               state_r;
   state_t               state_s;
   logic [3:0]           settle_cnt_r;
   logic [1:0]           word_idx_r;
   logic [3:0][15:0]     cap_r;
   logic [6:0]           acc_r;
   logic [6:0]           acc_sum_s;
   logic [15:0]          match_s;
   logic [4:0]           match_cnt_s;
   logic [ID_W-1:0]      cand_id_r;
   logic [6:0]           best_score_r;
   logic [ID_W-1:0]      best_id_r;
   logic [15:0]          a1_r, a0_r, b1_r, b0_r;
   logic                 res_valid_r;
   logic [6:0]           res_score_r;
   logic                 res_perfect_r;

   // One shared counter, steered to the word being scored this cycle.
   assign match_s   = ~(cap_r[word_idx_r] ^ gold_word(word_idx_r));
   assign acc_sum_s = acc_r + {2'b00, match_cnt_s};

   popcount16 u_popcount (
      .din   (match_s),
      .count (match_cnt_s)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_valid) state_s = ST_SETTLE;
            else             state_s = ST_IDLE;
         end
         ST_SETTLE: begin
            if (settle_cnt_r == SETTLE_LAST) state_s = ST_CAPTURE;
            else                             state_s = ST_SETTLE;
         end
         ST_CAPTURE: state_s = ST_SCORE;
         ST_SCORE: begin
            if (word_idx_r == 2'd3) state_s = ST_RESULT;
            else                    state_s = ST_SCORE;
         end
         ST_RESULT: begin
            if (res_ready) state_s = ST_IDLE;
            else           state_s = ST_RESULT;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath: stimulus, settle counter, capture, accumulation, result and best tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt_r  <= 4'd0;
         word_idx_r    <= 2'd0;
         cap_r         <= '0;
         acc_r         <= 7'd0;
         cand_id_r     <= '0;
         best_score_r  <= 7'd0;
         best_id_r     <= '0;
         a1_r          <= 16'h0000;
         a0_r          <= 16'h0000;
         b1_r          <= 16'h0000;
         b0_r          <= 16'h0000;
         res_valid_r   <= 1'b0;
         res_score_r   <= 7'd0;
         res_perfect_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_valid) begin
                  a1_r         <= STIM_A1;
                  a0_r         <= STIM_A0;
                  b1_r         <= STIM_B1;
                  b0_r         <= STIM_B0;
                  settle_cnt_r <= 4'd0;
                  word_idx_r   <= 2'd0;
                  acc_r        <= 7'd0;
               end
            end
            ST_SETTLE: begin
               settle_cnt_r <= settle_cnt_r + 4'd1;
            end
            ST_CAPTURE: begin
               cap_r <= {y3, y2, y1, y0};
            end
            ST_SCORE: begin
               acc_r      <= acc_sum_s;
               word_idx_r <= word_idx_r + 2'd1;
               if (word_idx_r == 2'd3) begin
                  a1_r          <= 16'h0000;
                  a0_r          <= 16'h0000;
                  b1_r          <= 16'h0000;
                  b0_r          <= 16'h0000;
                  res_valid_r   <= 1'b1;
                  res_score_r   <= acc_sum_s;
                  res_perfect_r <= (acc_sum_s == MAX_SCORE);
               end
            end
            ST_RESULT: begin
               if (res_ready) begin
                  res_valid_r <= 1'b0;
                  cand_id_r   <= cand_id_r + {{(ID_W-1){1'b0}}, 1'b1};
                  // Strictly greater: a tie keeps the earlier candidate.
                  if (acc_r > best_score_r) begin
                     best_score_r <= acc_r;
                     best_id_r    <= cand_id_r;
                  end
               end
            end
            default: begin
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign start_ready = (state_r == ST_IDLE);
   assign a1          = a1_r;
   assign a0          = a0_r;
   assign b1          = b1_r;
   assign b0          = b0_r;
   assign res_valid   = res_valid_r;
   assign res_score   = res_score_r;
   assign res_perfect = res_perfect_r;
   assign res_id      = cand_id_r;
   assign best_score  = best_score_r;
   assign best_id     = best_id_r;

endmodule
